spw_spill_sequencer: RTL and testbench

// Drives the SpaceWire receive-path spill (discard) enable from a timed state machine instead of a

---
 rtl/spw_spill_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spw_spill_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_spill_sequencer.sv
// SpaceWire RX spill sequencer: timed discard window after reset,
// link loss or software trigger, with an Avalon-MM register bank.
module spw_spill_sequencer #(
  parameter int CNT_W      = 16,
  parameter int EMPTY_QUAL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        link_running,
  input  logic        fifo_empty,
  output logic        spill_enable,
  output logic        spill_done
);

  localparam int ER_W = $clog2(EMPTY_QUAL + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [ER_W-1:0]  run_q, run_d;
  logic [ER_W-1:0]  run_nx;
  logic [CNT_W-1:0] holdoff_q, holdoff_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             auto_q, auto_d;
  logic             sticky_q, sticky_d;
  logic             pend_q, pend_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             link_q;
  logic             spill_en_q;
  logic             done_q;

  logic wr;
  logic wr_ctrl;
  logic trig;
  logic clr;
  logic link_fall;
  logic start_req;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == 2'd0);
  assign trig      = wr_ctrl & writedata[1];
  assign clr       = wr_ctrl & writedata[2];
  assign link_fall = link_q & ~link_running;
  assign start_req = trig | (auto_q & link_fall);
  assign unused_wd = ^writedata;

  // Register bank writes; HOLDOFF/TIMEOUT are compared live.
  always_comb begin
    auto_d    = auto_q;
    holdoff_d = holdoff_q;
    timeout_d = timeout_q;
    if (wr) begin
      unique case (address)
        2'd0:    auto_d    = writedata[0];
        2'd1:    holdoff_d = writedata[CNT_W-1:0];
        2'd2:    timeout_d = writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  assign run_nx = fifo_empty ? run_q + ER_W'(1) : '0;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    chk_d    = chk_q;
    run_d    = run_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr) sticky_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_req || pend_q) begin
          state_d = S_HOLD;
          hold_d  = '0;
          chk_d   = '0;
          run_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_HOLD: begin
        if (start_req) begin
          hold_d = '0;
          chk_d  = '0;
          run_d  = '0;
        end else if (hold_q == holdoff_q) begin
          state_d = S_CHECK;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (start_req) begin
          state_d = S_HOLD;
          hold_d  = '0;
          chk_d   = '0;
          run_d   = '0;
        end else begin
          run_d = run_nx;
          chk_d = chk_q + CNT_W'(1);
          // Empty qualification has priority over timeout.
          if (run_nx == ER_W'(EMPTY_QUAL)) begin
            state_d = S_DONE;
          end else if (timeout_q != '0 &&
                       chk_q == timeout_q - CNT_W'(1)) begin
            state_d  = S_DONE;
            sticky_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = cnt_q + 8'd1;
        if (start_req) pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HOLD;
      hold_q     <= '0;
      chk_q      <= '0;
      run_q      <= '0;
      holdoff_q  <= '0;
      timeout_q  <= '1;
      auto_q     <= 1'b1;
      sticky_q   <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      link_q     <= 1'b0;
      spill_en_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      chk_q      <= chk_d;
      run_q      <= run_d;
      holdoff_q  <= holdoff_d;
      timeout_q  <= timeout_d;
      auto_q     <= auto_d;
      sticky_q   <= sticky_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      link_q     <= link_running;
      spill_en_q <= (state_d == S_HOLD) || (state_d == S_CHECK);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign spill_enable = spill_en_q;
  assign spill_done   = done_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[0] = auto_q;
      2'd1: readdata[CNT_W-1:0] = holdoff_q;
      2'd2: readdata[CNT_W-1:0] = timeout_q;
      2'd3: begin
        readdata[1:0]  = state_q;
        readdata[2]    = sticky_q;
        readdata[3]    = link_running;
        readdata[15:8] = cnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spw_spill_sequencer.sv
// Bench for spw_spill_sequencer: directed scenarios plus random
// spills checked against a window-scan model of spill duration.
module tb_spw_spill_sequencer;

  localparam int Q  = 2;
  localparam int PN = 96;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        link_running;
  logic        fifo_empty;
  logic        spill_enable;
  logic        spill_done;

  int n_assert = 0;
  int n_fail   = 0;
  bit p [PN];
  logic [7:0] exp_cnt;
  bit exp_sticky;

  spw_spill_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .link_running (link_running),
    .fifo_empty   (fifo_empty),
    .spill_enable (spill_enable),
    .spill_done   (spill_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  function automatic logic [31:0] status_exp(input int st);
    logic [31:0] v;
    v        = '0;
    v[1:0]   = st[1:0];
    v[2]     = exp_sticky;
    v[3]     = link_running;
    v[15:8]  = exp_cnt;
    return v;
  endfunction

  // First CHECK cycle that closes a spill: a window of Q empties
  // fully inside CHECK, else the TIMEOUT-th cycle (0 = never).
  task automatic calc_exit(input int t, output int ie, output bit tmo);
    bit win;
    ie  = PN - 2;
    tmo = 1'b0;
    for (int i = 0; i < PN - 1; i++) begin
      win = (i >= Q - 1);
      for (int j = 0; j < Q; j++)
        if (i - j >= 0 && !p[i - j]) win = 1'b0;
      if (win) begin
        ie = i;
        return;
      end
      if (t != 0 && i == t - 1) begin
        ie  = i;
        tmo = 1'b1;
        return;
      end
    end
  endtask

  task automatic follow_spill(input int h, input int ie, input bit tmo);
    logic [31:0] d;
    for (int k = 1; k <= h + 3 + ie; k++) begin
      if (k >= h + 2) fifo_empty = p[k - h - 2];
      else fifo_empty = 1'($urandom_range(0, 1));
      tick();
      chk("spill_enable", {31'b0, spill_enable},
          (k <= h + 1 + ie) ? 32'd1 : 32'd0);
      chk("spill_done", {31'b0, spill_done},
          (k == h + 2 + ie) ? 32'd1 : 32'd0);
    end
    if (tmo) exp_sticky = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    bus_rd(2'd3, d);
    chk("status_after_spill", d, status_exp(0));
  endtask

  task automatic start_spill(input int h, input int t);
    bus_wr(2'd1, 32'(h));
    bus_wr(2'd2, 32'(t));
    bus_wr(2'd0, 32'h7);
    exp_sticky = 1'b0;
    chk("start_enable", {31'b0, spill_enable}, 32'd1);
  endtask

  task automatic fill(input bit v);
    for (int i = 0; i < PN; i++) p[i] = v;
  endtask

  initial begin
    logic [31:0] d;
    int ie;
    bit tmo;
    int h;
    int t;

    reset        = 1'b1;
    address      = 2'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = '0;
    link_running = 1'b1;
    fifo_empty   = 1'b1;
    exp_cnt      = 8'd0;
    exp_sticky   = 1'b0;

    // Reset: spill held, register table at reset values
    tick();
    tick();
    chk("rst_enable", {31'b0, spill_enable}, 32'd1);
    chk("rst_done", {31'b0, spill_done}, 32'd0);
    bus_rd(2'd0, d); chk("rst_ctrl", d, 32'h1);
    bus_rd(2'd1, d); chk("rst_holdoff", d, 32'h0);
    bus_rd(2'd2, d); chk("rst_timeout", d, 32'hFFFF);
    bus_rd(2'd3, d); chk("rst_status", d, 32'h9);
    reset = 1'b0;
    fill(1'b1);
    follow_spill(0, 1, 1'b0);

    // HOLDOFF=10, FIFO already empty
    fill(1'b1);
    start_spill(10, 32'hFFFF);
    calc_exit(32'hFFFF, ie, tmo);
    follow_spill(10, ie, tmo);

    // Timeout with FIFO never empty, then clear sticky
    fill(1'b0);
    start_spill(1, 20);
    calc_exit(20, ie, tmo);
    chk("tmo_model", 32'(ie), 32'd19);
    follow_spill(1, ie, tmo);
    bus_wr(2'd0, 32'h4);
    exp_sticky = 1'b0;
    bus_rd(2'd3, d); chk("sticky_clr", d, status_exp(0));
    bus_rd(2'd0, d); chk("ctrl_auto_off", d, 32'h0);
    bus_wr(2'd0, 32'h1);

    // Broken empty run 1,0,1,1
    fill(1'b0);
    p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; p[3] = 1'b1;
    start_spill(0, 0);
    calc_exit(0, ie, tmo);
    follow_spill(0, ie, tmo);

    // Retrigger in CHECK restarts HOLD without counting a spill
    start_spill(2, 0);
    fifo_empty = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    bus_rd(2'd3, d); chk("in_check", d, status_exp(2));
    bus_wr(2'd0, 32'h7);
    chk("retrig_enable", {31'b0, spill_enable}, 32'd1);
    bus_rd(2'd3, d); chk("retrig_hold", d, status_exp(1));
    fill(1'b1);
    follow_spill(2, 1, 1'b0);

    // Link drop with auto_en on, then with auto_en off
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd2, 32'd0);
    link_running = 1'b0;
    tick();
    chk("link_drop_en", {31'b0, spill_enable}, 32'd1);
    fill(1'b1);
    follow_spill(0, 1, 1'b0);
    link_running = 1'b1;
    tick();
    tick();
    bus_wr(2'd0, 32'h0);
    link_running = 1'b0;
    tick();
    chk("no_auto_en", {31'b0, spill_enable}, 32'd0);
    tick();
    chk("no_auto_en2", {31'b0, spill_enable}, 32'd0);
    bus_rd(2'd3, d); chk("no_auto_idle", d, status_exp(0));
    bus_wr(2'd0, 32'h1);
    link_running = 1'b1;
    tick();
    chk("link_rise_idle", {31'b0, spill_enable}, 32'd0);

    // Random spills against the window-scan model
    for (int n = 0; n < 30; n++) begin
      h = $urandom_range(0, 5);
      t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
      for (int i = 0; i < PN; i++) p[i] = ($urandom_range(0, 3) != 0);
      p[70] = 1'b1;
      p[71] = 1'b1;
      start_spill(h, t);
      calc_exit(t, ie, tmo);
      follow_spill(h, ie, tmo);
    end

    // Reset in the middle of CHECK
    fill(1'b0);
    start_spill(3, 50);
    bus_wr(2'd0, 32'h6);
    fifo_empty = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    bus_rd(2'd3, d); chk("pre_rst_check", d, status_exp(2));
    reset = 1'b1;
    tick();
    exp_cnt    = 8'd0;
    exp_sticky = 1'b0;
    chk("mid_rst_enable", {31'b0, spill_enable}, 32'd1);
    bus_rd(2'd0, d); chk("mid_rst_ctrl", d, 32'h1);
    bus_rd(2'd1, d); chk("mid_rst_holdoff", d, 32'h0);
    bus_rd(2'd2, d); chk("mid_rst_timeout", d, 32'hFFFF);
    bus_rd(2'd3, d); chk("mid_rst_status", d, status_exp(1));
    reset = 1'b0;
    fill(1'b1);
    follow_spill(0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
